display_scan_mux: RTL
=====================

# display_scan_mux

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. Sits directly upstream of the binary-to-hex segment decoder: it holds a 16-bit value and presents one 4-bit nibble at a time on `nib`, which feeds the decoder's `bina` input. At the same time it drives the matching active-low digit anode and decimal point. The block also provides frame-synchronous value update, an anti-ghosting guard interval, and optional leading-zero blanking.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range ≥ 4.
- `GUARD`, 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ GUARD < DIV.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `value`  in  16  number to display; nibble i goes to digit i, digit 0 is rightmost.
- `load`  in  1  capture strobe for `value` and `dp_in`.
- `dp_in`  in  4  decimal-point request per digit; 1 = lit.
- `lzb`  in  1  leading-zero blanking enable; sampled every cycle.
- `nib`  out  4  nibble for the current digit; connects to the decoder's `bina`.
- `an`  out  4  digit anodes, active-low, one-hot-low or all 1.
- `dp_n`  out  1  decimal point, active-low; ANDed with decoder output bit 0 at top level.
- `frame`  out  1  one-cycle pulse on the last cycle of a frame.

## Operation
- Registers:
  - `cnt` (0..DIV-1), slot counter.
  - `idx` (0..3), current digit.
  - `pend_v`/`pend_dp`, pending value and dp.
  - `act_v`/`act_dp`, displayed value and dp.
- Slot counter: `cnt` increments every cycle. At DIV-1 it wraps to 0 and `idx` advances mod 4 (3→0).
- Frame boundary is the wrap with `idx`=3. On that edge `act_v` <= `pend_v` and `act_dp` <= `pend_dp`.
- `load`=1 captures `value`/`dp_in` into the pending registers on that edge. The new value is never shown mid-frame, so there is no tearing.
- Load coincident with frame boundary: the active registers take the old pending contents. The new load is shown one frame later. The last `load` before a boundary wins.
- Phases within each slot:
  - GUARD (`cnt` < GUARD): `an`=1111 and `dp_n`=1.
  - DRIVE (otherwise): `an` has bit `idx` low and the other bits high; `dp_n` = ~`act_dp[idx]`.
- `nib` = `act_v[4*idx+3 -: 4]` throughout the slot, including GUARD, so the decoder settles before the anode enables.
- Leading-zero blanking applies when `lzb`=1 and `idx`>0:
  - Digit `idx` is blanked if the `act_v` nibbles `idx`..3 are all zero and `act_dp` bits `idx`..3 are all zero.
  - A blanked digit keeps `an`=1111 and `dp_n`=1 for its whole slot.
  - Digit 0 is never blanked.
- `frame`=1 exactly when `idx`=3 and `cnt`=DIV-1.
- Output style: all outputs are Moore functions of registered state, either registered directly or decoded from registers without any input-to-output path. Exception: `lzb` may be used combinationally for blanking.

## Timing
- Reset values (rst=1 on a clock edge, taking effect that edge):
  - `cnt`=0, `idx`=0.
  - Pending and active registers = 0.
  - `an`=1111, `nib`=0000, `dp_n`=1, `frame`=0.
- The first cycle after reset release is digit 0, `cnt`=0, GUARD phase.
- Reset mid-slot or mid-frame aborts the scan immediately and discards pending data. No partial-slot state survives.
- Slot = DIV cycles; frame = 4·DIV cycles. Defaults at 50 MHz give 1 ms per slot and a 250 Hz refresh.
- Load-to-display latency ranges from 1 cycle + remainder of the current frame up to 4·DIV + 1 cycles. The value first appears at the digit-0 slot following the next boundary.
- Output changes align to the `cnt` transition edge; there is no extra pipeline stage.
- Per slot, `an` is low for exactly DIV-GUARD cycles.

## Test plan
Benches use DIV=8 and GUARD=2, so a frame is 32 cycles.
1. Reset and idle:
   - Stimulus: hold rst 3 cycles, then release.
   - During reset: `an`=1111, `nib`=0, `dp_n`=1, `frame`=0.
   - After release: cycles 0–1 `an`=1111; cycles 2–7 `an`=1110 with `nib`=0; cycle 8 starts digit 1 in GUARD; `frame` is high at cycle 31 only.
2. Frame-synchronous load:
   - Stimulus: `load` with `value`=16'h1234 at cycle 12 (digit 1 slot).
   - Cycles 12–31 still show 0.
   - From cycle 32, slots show `nib`=4,3,2,1 with `an`=1110,1101,1011,0111 in DRIVE.
3. Leading-zero blanking:
   - Stimulus: `lzb`=1, `value`=16'h0050, applied through a frame.
   - Digits 3 and 2: `an`=1111 for all 8 cycles.
   - Digit 1: `nib`=5, drives normally. Digit 0: `nib`=0, drives normally.
   - With `value`=16'h0000, only digit 0 drives.
4. Decimal point overrides blanking:
   - Stimulus: `lzb`=1, `value`=16'h0001, `dp_in`=4'b0100.
   - Digit 3 is blanked.
   - Digit 2 drives `nib`=0 with `dp_n`=0 in DRIVE and `dp_n`=1 in GUARD.
   - Digit 1 drives `nib`=0; digit 0 drives `nib`=1.
5. Load on the boundary:
   - Stimulus: load 16'hAAAA at cycle 5, then load 16'hBBBB exactly at cycle 31, where `frame`=1.
   - Frame 2 shows A on all digits; frame 3 shows B.
6. Reset mid-operation:
   - Stimulus: load 16'hFFFF with `dp_in`=1111, let it display, then assert rst at cycle 70 (digit 0 slot, DRIVE).
   - Next edge: all reset values.
   - After release, a full frame shows 0 with all `dp_n`=1.

Source files
------------

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display. Holds a pending and an active copy of the
// displayed value. The active copy only changes at frame boundaries, so a
// frame never shows a mix of old and new digits. Each digit slot opens with
// a guard interval in which all anodes are off, to prevent ghosting.
module display_scan_mux #(
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lzb,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame
);

    localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_GUARD = CW'(GUARD);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_pend_v;
    logic [3:0]    r_pend_dp;
    logic [15:0]   r_act_v;
    logic [3:0]    r_act_dp;

    logic          w_wrap;
    logic          w_boundary;
    logic          w_guard;
    logic          w_blank;
    logic [3:0]    w_blankable;

    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_boundary = w_wrap && (r_idx == 2'd3);
    assign w_guard    = (r_cnt < CNT_GUARD);

    // A digit may be blanked when it and every digit to its left hold zero
    // and none of those digits requests a decimal point.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blankable
            assign w_blankable[gi] = (r_act_v[15:4*gi] == '0) &&
                                     (r_act_dp[3:gi] == '0);
        end
    endgenerate

    // Digit 0 always shows, even when the whole value is zero.
    assign w_blank = lzb && (r_idx != 2'd0) && w_blankable[r_idx];

    // Slot/digit counters and the frame-synchronous pending->active transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= 2'd0;
            r_pend_v  <= 16'h0000;
            r_pend_dp <= 4'h0;
            r_act_v   <= 16'h0000;
            r_act_dp  <= 4'h0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
            // On a boundary the active copy takes the pending contents held
            // before this edge; a coincident load waits one more frame.
            if (w_boundary) begin
                r_act_v  <= r_pend_v;
                r_act_dp <= r_pend_dp;
            end
            if (load) begin
                r_pend_v  <= value;
                r_pend_dp <= dp_in;
            end
        end
    end

    // Output decode from registered state. nib is presented for the whole
    // slot so the segment decoder settles before the anode turns on.
    always_comb begin
        nib   = r_act_v[{r_idx, 2'b00} +: 4];
        an    = 4'b1111;
        dp_n  = 1'b1;
        frame = w_boundary;
        if (!w_guard && !w_blank) begin
            an[r_idx] = 1'b0;
            dp_n      = ~r_act_dp[r_idx];
        end
    end

endmodule
